// File: rtl/ex_stage.sv
// Execute stage of the 16-bit five-stage pipeline: ALU, shifts, address generation,
// flag maintenance and branch resolution, registered toward the memory stage.
module ex_stage #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             state,
    input  logic [WIDTH-1:0] ex_ir,
    input  logic [WIDTH-1:0] reg_A,
    input  logic [WIDTH-1:0] reg_B,
    input  logic [WIDTH-1:0] smdr,
    output logic [WIDTH-1:0] mem_ir,
    output logic [WIDTH-1:0] reg_C,
    output logic [WIDTH-1:0] smdr1,
    output logic             dw,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             branch_flag,
    output logic [WIDTH-1:0] branch_target
);

    localparam logic STATE_EXEC = 1'b1;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    logic [4:0]         op_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     addc_s;
    logic [WIDTH:0]     sub_s;
    logic [WIDTH:0]     subc_s;
    logic [WIDTH-1:0]   addr_s;
    logic [WIDTH-1:0]   sll_s;
    logic [WIDTH-1:0]   c_s;
    logic               flag_we_s;
    logic               cf_we_s;
    logic               cf_next_s;
    logic               taken_s;
    logic               store_s;

    // Arithmetic candidates; bit WIDTH of each 17-bit result is the carry/borrow.
    always_comb begin
        op_s    = ex_ir[WIDTH-1:WIDTH-5];
        shamt_s = reg_B[SHAMT_W-1:0];
        add_s   = {1'b0, reg_A} + {1'b0, reg_B};
        addc_s  = {1'b0, reg_A} + {1'b0, reg_B} + {{WIDTH{1'b0}}, cf};
        sub_s   = {1'b0, reg_A} - {1'b0, reg_B};
        subc_s  = {1'b0, reg_A} - {1'b0, reg_B} - {{WIDTH{1'b0}}, cf};
        addr_s  = reg_A + reg_B;
        sll_s   = reg_A << shamt_s;
    end

    // Opcode decode: result, flag write enables and branch decision.
    always_comb begin
        c_s       = {WIDTH{1'b0}};
        flag_we_s = 1'b0;
        cf_we_s   = 1'b0;
        cf_next_s = cf;
        taken_s   = 1'b0;
        store_s   = 1'b0;
        case (op_s)
            OP_ADD, OP_ADDI, OP_LDIH, OP_LOAD, OP_STORE: begin
                c_s       = add_s[WIDTH-1:0];
                flag_we_s = 1'b1;
                cf_we_s   = 1'b1;
                cf_next_s = add_s[WIDTH];
                store_s   = (op_s == OP_STORE);
            end
            OP_ADDC: begin
                c_s       = addc_s[WIDTH-1:0];
                flag_we_s = 1'b1;
                cf_we_s   = 1'b1;
                cf_next_s = addc_s[WIDTH];
            end
            OP_SUB, OP_SUBI, OP_CMP: begin
                c_s       = sub_s[WIDTH-1:0];
                flag_we_s = 1'b1;
                cf_we_s   = 1'b1;
                cf_next_s = sub_s[WIDTH];
            end
            OP_SUBC: begin
                c_s       = subc_s[WIDTH-1:0];
                flag_we_s = 1'b1;
                cf_we_s   = 1'b1;
                cf_next_s = subc_s[WIDTH];
            end
            OP_AND: begin
                c_s       = reg_A & reg_B;
                flag_we_s = 1'b1;
            end
            OP_OR: begin
                c_s       = reg_A | reg_B;
                flag_we_s = 1'b1;
            end
            OP_XOR: begin
                c_s       = reg_A ^ reg_B;
                flag_we_s = 1'b1;
            end
            OP_SLL: begin
                c_s       = sll_s;
                flag_we_s = 1'b1;
            end
            OP_SRL: begin
                c_s       = reg_A >> shamt_s;
                flag_we_s = 1'b1;
            end
            OP_SRA: begin
                c_s       = $unsigned($signed(reg_A) >>> shamt_s);
                flag_we_s = 1'b1;
            end
            OP_SLA: begin
                c_s       = {reg_A[WIDTH-1], sll_s[WIDTH-2:0]};
                flag_we_s = 1'b1;
            end
            OP_JUMP, OP_JMPR: begin
                c_s     = addr_s;
                taken_s = 1'b1;
            end
            OP_BZ: begin
                c_s     = addr_s;
                taken_s = zf;
            end
            OP_BNZ: begin
                c_s     = addr_s;
                taken_s = ~zf;
            end
            OP_BN: begin
                c_s     = addr_s;
                taken_s = nf;
            end
            OP_BNN: begin
                c_s     = addr_s;
                taken_s = ~nf;
            end
            OP_BC: begin
                c_s     = addr_s;
                taken_s = cf;
            end
            OP_BNC: begin
                c_s     = addr_s;
                taken_s = ~cf;
            end
            OP_NOP, OP_HALT: begin
                c_s = {WIDTH{1'b0}};
            end
            default: begin
                c_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Pipeline registers; an instruction behind a taken branch is squashed to a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ir        <= {WIDTH{1'b0}};
            reg_C         <= {WIDTH{1'b0}};
            smdr1         <= {WIDTH{1'b0}};
            dw            <= 1'b0;
            zf            <= 1'b0;
            nf            <= 1'b0;
            cf            <= 1'b0;
            branch_flag   <= 1'b0;
            branch_target <= {WIDTH{1'b0}};
        end else if (state == STATE_EXEC) begin
            smdr1 <= smdr;
            if (branch_flag) begin
                mem_ir      <= {WIDTH{1'b0}};
                reg_C       <= {WIDTH{1'b0}};
                dw          <= 1'b0;
                branch_flag <= 1'b0;
            end else begin
                mem_ir      <= ex_ir;
                reg_C       <= c_s;
                dw          <= store_s;
                branch_flag <= taken_s;
                if (flag_we_s) begin
                    zf <= (c_s == {WIDTH{1'b0}});
                    nf <= c_s[WIDTH-1];
                end
                if (cf_we_s) begin
                    cf <= cf_next_s;
                end
                if (taken_s) begin
                    branch_target <= addr_s;
                end
            end
        end
    end

endmodule
